// File: rtl/mem_dual.sv
// MEM stage of a dual-issue pipeline: pipeline register, load-data alignment and
// a hold buffer that keeps load data stable across WB stalls. Optional macro MEM_FWD_EN.
module mem_dual (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [5:0]   stall,
    input  logic [150:0] ex_to_mem_bus,
    input  logic [31:0]  data_sram_rdata,
    output logic [141:0] mem_to_wb_bus,
    output logic [75:0]  mem_to_rf_bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } ld_state_e;

    logic [150:0] bus_q, bus_d;
    logic [31:0]  hold_q, hold_d;
    ld_state_e    state_q, state_d;

    logic         stop_mem_s;
    logic         stop_wb_s;
    logic         bubble_s;
    logic         in_mem_load_s;
    logic         unused_stall_s;

    logic         switch_s;
    logic         valid_hi_s;
    logic         valid_lo_s;
    logic [73:0]  slot_hi_s;
    logic [73:0]  slot_lo_s;
    logic [31:0]  load_word_s;
    logic [69:0]  wb_hi_s;
    logic [69:0]  wb_lo_s;

    // Byte/halfword lane selection with sign or zero extension; unknown ops pass the word.
    function automatic logic [31:0] ld_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  op);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        if (lane[1]) begin
            half_v = word[31:16];
        end else begin
            half_v = word[15:0];
        end
        case (op)
            3'd1:    res_v = {{24{byte_v[7]}}, byte_v};
            3'd2:    res_v = {24'd0, byte_v};
            3'd3:    res_v = {{16{half_v[15]}}, half_v};
            3'd4:    res_v = {16'd0, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    // Build one {pc, we, waddr, wdata} entry; only the memory slot may use load data.
    function automatic logic [69:0] wb_entry(input logic [73:0] slot,
                                             input logic        valid,
                                             input logic        is_mem,
                                             input logic [31:0] word);
        logic [31:0] wdata_v;
        if (is_mem && slot[3]) begin
            wdata_v = ld_extend(word, slot[5:4], slot[2:0]);
        end else begin
            wdata_v = slot[35:4];
        end
        return {slot[73:42], valid & slot[41], slot[40:36], wdata_v};
    endfunction

    assign stop_mem_s     = stall[4];
    assign stop_wb_s      = stall[5];
    assign bubble_s       = stop_mem_s & ~stop_wb_s;
    assign unused_stall_s = ^stall[3:0];

    assign in_mem_load_s = ex_to_mem_bus[150] ? (ex_to_mem_bus[149] & ex_to_mem_bus[77])
                                              : (ex_to_mem_bus[148] & ex_to_mem_bus[3]);

    // Next-state for the pipeline register, load-data FSM and hold buffer.
    always_comb begin
        bus_d   = bus_q;
        state_d = state_q;
        hold_d  = hold_q;
        if (flush || bubble_s) begin
            bus_d   = 151'd0;
            state_d = IDLE;
            hold_d  = 32'd0;
        end else if (!stop_mem_s) begin
            bus_d   = ex_to_mem_bus;
            state_d = in_mem_load_s ? FRESH : IDLE;
            hold_d  = 32'd0;
        end else begin
            case (state_q)
                FRESH: begin
                    state_d = HELD;
                    hold_d  = data_sram_rdata;
                end
                HELD:    state_d = HELD;
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q   <= 151'd0;
            hold_q  <= 32'd0;
            state_q <= IDLE;
        end else begin
            bus_q   <= bus_d;
            hold_q  <= hold_d;
            state_q <= state_d;
        end
    end

    assign switch_s    = bus_q[150];
    assign valid_hi_s  = bus_q[149];
    assign valid_lo_s  = bus_q[148];
    assign slot_hi_s   = bus_q[147:74];
    assign slot_lo_s   = bus_q[73:0];
    // Once the response has been captured the SRAM bus may move on, so read the buffer.
    assign load_word_s = (state_q == HELD) ? hold_q : data_sram_rdata;

    assign wb_hi_s = wb_entry(slot_hi_s, valid_hi_s, switch_s, load_word_s);
    assign wb_lo_s = wb_entry(slot_lo_s, valid_lo_s, ~switch_s, load_word_s);

    assign mem_to_wb_bus = {valid_hi_s, valid_lo_s, wb_hi_s, wb_lo_s};

`ifdef MEM_FWD_EN
    assign mem_to_rf_bus = {wb_hi_s[37:0], wb_lo_s[37:0]};
`else
    assign mem_to_rf_bus = 76'd0;
`endif

endmodule

// File: tb/tb_mem_dual.sv
// Self-checking bench for mem_dual: directed scenarios plus randomized traffic
// against a behavioural model of the MEM stage.
module tb_mem_dual;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [5:0]   stall;
    logic [150:0] bus;
    logic [31:0]  rdata;
    logic [141:0] wb;
    logic [75:0]  rf;

    int errs   = 0;
    int checks = 0;

    // Model: last accepted bus word, and whether a load response has been frozen.
    logic [150:0] m_reg;
    bit           m_held;
    logic [31:0]  m_word;

    mem_dual dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .stall           (stall),
        .ex_to_mem_bus   (bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb),
        .mem_to_rf_bus   (rf)
    );

    always #5 clk = ~clk;

    function automatic logic [73:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                       input logic [31:0] res, input logic ld, input logic [2:0] op);
        return {pc, we, wa, res, ld, op};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] addr,
                                             input logic [2:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (int'(addr[1:0]) * 8));
        h = 16'(w >> (int'(addr[1]) * 16));
        case (op)
            3'd1:    return {{24{b[7]}}, b};
            3'd2:    return {24'd0, b};
            3'd3:    return {{16{h[15]}}, h};
            3'd4:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [69:0] ref_entry(input logic [73:0] s, input logic v,
                                              input logic is_mem, input logic [31:0] word);
        logic [31:0] wd;
        wd = (is_mem && s[3]) ? ref_load(word, s[35:4], s[2:0]) : s[35:4];
        return {s[73:42], v & s[41], s[40:36], wd};
    endfunction

    function automatic bit is_mem_load(input logic [150:0] r);
        return r[150] ? (r[149] && r[77]) : (r[148] && r[3]);
    endfunction

    function automatic logic [141:0] ref_wb();
        logic [31:0] word;
        word = m_held ? m_word : rdata;
        return {m_reg[149], m_reg[148],
                ref_entry(m_reg[147:74], m_reg[149], m_reg[150], word),
                ref_entry(m_reg[73:0], m_reg[148], !m_reg[150], word)};
    endfunction

    task automatic check(input logic [141:0] obs, input logic [141:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [141:0] e;
        logic [75:0]  erf;
        e = ref_wb();
`ifdef MEM_FWD_EN
        erf = {e[107:70], e[37:0]};
`else
        erf = 76'd0;
`endif
        check(wb, e, {tag, "_wb"});
        check({66'd0, rf}, {66'd0, erf}, {tag, "_rf"});
    endtask

    task automatic model_reset();
        m_reg  = 151'd0;
        m_held = 1'b0;
        m_word = 32'd0;
    endtask

    task automatic model_edge();
        if (flush || (stall[4] && !stall[5])) begin
            m_reg  = 151'd0;
            m_held = 1'b0;
        end else if (!stall[4]) begin
            m_reg  = bus;
            m_held = 1'b0;
        end else if (!m_held && is_mem_load(m_reg)) begin
            m_held = 1'b1;
            m_word = rdata;
        end
    endtask

    task automatic drive(input logic fl, input logic [5:0] st, input logic [150:0] b,
                         input logic [31:0] rd, input string tag);
        flush = fl;
        stall = st;
        bus   = b;
        rdata = rd;
        #1;
        check_model(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check(wb, 142'd0, {tag, "_wb"});
        check({66'd0, rf}, 142'd0, {tag, "_rf"});
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [150:0] b_lb, b_lbu, b_lh, b_alu, b_sw;

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        stall = 6'd0;
        bus   = 151'd0;
        rdata = 32'hDEADBEEF;
        model_reset();
        #1;
        check(wb, 142'd0, "reset_wb");
        check({66'd0, rf}, 142'd0, "reset_rf");
        @(negedge clk);
        rst = 1'b0;

        // Byte loads from lane 2, signed then unsigned.
        b_lb  = {1'b0, 1'b0, 1'b1, mk(32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0),
                 mk(32'h100, 1'b1, 5'd7, 32'h1002, 1'b1, 3'd1)};
        b_lbu = {1'b0, 1'b0, 1'b1, mk(32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0),
                 mk(32'h104, 1'b1, 5'd7, 32'h1002, 1'b1, 3'd2)};
        drive(1'b0, 6'd0, b_lb, 32'h0, "lb_issue");
        tick();
        drive(1'b0, 6'd0, b_lbu, 32'h80FF7F01, "lb_data");
        check({110'd0, wb[31:0]}, 142'hFFFFFFFF, "lb_wdata");
        tick();
        drive(1'b0, 6'd0, 151'd0, 32'h80FF7F01, "lbu_data");
        check({110'd0, wb[31:0]}, 142'h000000FF, "lbu_wdata");
        tick();

        // Halfword load held across a 3-cycle WB stall while rdata changes.
        b_lh = {1'b0, 1'b0, 1'b1, mk(32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0),
                mk(32'h200, 1'b1, 5'd9, 32'h2002, 1'b1, 3'd3)};
        drive(1'b0, 6'd0, b_lh, 32'h0, "lh_issue");
        tick();
        drive(1'b0, 6'b110000, 151'd0, 32'h80011234, "lh_fresh");
        check({110'd0, wb[31:0]}, 142'hFFFF8001, "lh_fresh_wdata");
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 6'b110000, 151'd0, 32'h0, "lh_held");
            check({110'd0, wb[31:0]}, 142'hFFFF8001, "lh_held_wdata");
            tick();
        end

        // Flush overrides the hold while HELD.
        drive(1'b1, 6'b110000, b_lh, 32'h0, "flush_req");
        tick();
        drive(1'b0, 6'b110000, 151'd0, 32'h1234, "after_flush");
        check(wb, 142'd0, "flush_cleared");

        // Bubble inserted by MEM stop with WB running.
        b_alu = {1'b0, 1'b1, 1'b1, mk(32'h300, 1'b1, 5'd4, 32'h77, 1'b0, 3'd0),
                 mk(32'h2FC, 1'b1, 5'd5, 32'h66, 1'b0, 3'd0)};
        drive(1'b0, 6'd0, b_alu, 32'h0, "bubble_load");
        tick();
        drive(1'b0, 6'b010000, b_alu, 32'h0, "bubble_req");
        tick();
        drive(1'b0, 6'b110000, 151'd0, 32'h0, "bubble");
        check({138'd0, wb[141:140], wb[107], wb[37]}, 142'd0, "bubble_valid_we");

        // Memory op in hi slot; lo slot's is_load bit must be ignored.
        b_sw = {1'b1, 1'b1, 1'b1, mk(32'h404, 1'b1, 5'd9, 32'h2000, 1'b1, 3'd0),
                mk(32'h400, 1'b1, 5'd3, 32'd5, 1'b1, 3'd1)};
        drive(1'b0, 6'd0, b_sw, 32'h0, "switch_issue");
        tick();
        drive(1'b0, 6'd0, 151'd0, 32'hCAFEF00D, "switch");
        check({110'd0, wb[31:0]}, 142'd5, "switch_lo");
        check({110'd0, wb[101:70]}, 142'hCAFEF00D, "switch_hi");
`ifndef MEM_FWD_EN
        check({66'd0, rf}, 142'd0, "switch_rf_off");
`endif
        tick();

        // Reset mid-HELD clears outputs before the next edge.
        drive(1'b0, 6'd0, b_lh, 32'h0, "rst_issue");
        tick();
        drive(1'b0, 6'b110000, 151'd0, 32'h80011234, "rst_fresh");
        tick();
        drive(1'b0, 6'b110000, 151'd0, 32'h0, "rst_held");
        async_reset("rst_mid_held");
        drive(1'b0, 6'b110000, 151'd0, 32'hFFFF0000, "post_reset");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [150:0] rb;
            logic [5:0]   rs;
            rb = {1'(($urandom)), 1'(($urandom)), 1'(($urandom)),
                  mk($urandom, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 3'($urandom_range(0, 7))),
                  mk($urandom, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 3'($urandom_range(0, 7)))};
            rs = 6'($urandom);
            drive(1'($urandom_range(0, 15) == 0), rs, rb, $urandom, "rand");
            if (i % 97 == 50) begin
                async_reset("rand_rst");
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
